// File: rtl/gpr_wb_scheduler.sv
// GPR writeback scheduler: busy scoreboard for issue hazards, plus a round-robin
// arbiter that merges EXU (A) and LSU (B) writebacks into one register-file write port.
module gpr_wb_scheduler #(
    parameter int REG_NUM = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_iss_valid,
    input  logic              i_iss_rd_wen,
    input  logic [4:0]        i_iss_rd_id,
    input  logic [4:0]        i_iss_rs_id1,
    input  logic [4:0]        i_iss_rs_id2,
    output logic              o_iss_stall,
    input  logic              i_a_valid,
    input  logic [4:0]        i_a_rd_id,
    input  logic [DATA_W-1:0] i_a_data,
    output logic              o_a_ready,
    input  logic              i_b_valid,
    input  logic [4:0]        i_b_rd_id,
    input  logic [DATA_W-1:0] i_b_data,
    output logic              o_b_ready,
    output logic              o_rf_gpr_wen,
    output logic [4:0]        o_rf_rd_id,
    output logic [DATA_W-1:0] o_rf_rd
);

    localparam logic [REG_NUM-1:0] ZERO_MASK = {{(REG_NUM-1){1'b1}}, 1'b0};

    logic [REG_NUM-1:0] busy;
    logic [REG_NUM-1:0] busy_next;
    logic [REG_NUM-1:0] set_mask;
    logic [REG_NUM-1:0] clr_mask;
    logic               last_b;
    logic               xfer;
    logic               issue_set;
    logic [4:0]         wb_rd;
    logic [DATA_W-1:0]  wb_data;

    assign o_iss_stall = !rst && i_iss_valid &&
                         (busy[i_iss_rs_id1] || busy[i_iss_rs_id2] ||
                          (i_iss_rd_wen && busy[i_iss_rd_id]));

    assign issue_set = !rst && i_iss_valid && !o_iss_stall && i_iss_rd_wen &&
                       (i_iss_rd_id != 5'd0);

    // On contention the requester that did not win last time gets the port
    always_comb begin
        o_a_ready = 1'b0;
        o_b_ready = 1'b0;
        if (!rst) begin
            if (i_a_valid && i_b_valid) begin
                o_a_ready = last_b;
                o_b_ready = !last_b;
            end else begin
                o_a_ready = i_a_valid;
                o_b_ready = i_b_valid;
            end
        end
    end

    assign xfer    = (i_a_valid && o_a_ready) || (i_b_valid && o_b_ready);
    assign wb_rd   = o_a_ready ? i_a_rd_id : i_b_rd_id;
    assign wb_data = o_a_ready ? i_a_data  : i_b_data;

    // Clear is applied before set so a same-cycle reissue keeps the register busy
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_set) begin
            set_mask[i_iss_rd_id] = 1'b1;
        end
        if (xfer && (wb_rd != 5'd0)) begin
            clr_mask[wb_rd] = 1'b1;
        end
        busy_next = ((busy & ~clr_mask) | set_mask) & ZERO_MASK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy         <= '0;
            last_b       <= 1'b1;
            o_rf_gpr_wen <= 1'b0;
            o_rf_rd_id   <= '0;
            o_rf_rd      <= '0;
        end else begin
            busy <= busy_next;
            if (xfer) begin
                last_b       <= o_b_ready;
                o_rf_gpr_wen <= (wb_rd != 5'd0);
                o_rf_rd_id   <= wb_rd;
                o_rf_rd      <= wb_data;
            end else begin
                o_rf_gpr_wen <= 1'b0;
            end
        end
    end

endmodule
